// File: rtl/lsq_multi_cdb_pkg.sv
// Shared definitions for the multi-CDB load/store queue.
// Contents: memory op encodings, FSM state type, the "no dependency" tag,
// the default MMIO address and a helper that locates a channel inside a
// packed broadcast bus.
package lsq_multi_cdb_pkg;

  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LH  = 4'd1,
    OP_LW  = 4'd2,
    OP_LBU = 4'd3,
    OP_LHU = 4'd4,
    OP_SB  = 4'd5,
    OP_SH  = 4'd6,
    OP_SW  = 4'd7
  } lsq_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_WAIT
  } lsq_state_e;

  // Tag value meaning "operand already resolved".
  localparam int unsigned TAG_NONE = 0;

  localparam logic [31:0] IO_ADDR_DEFAULT = 32'h0003_0000;

  function automatic logic is_store_op(input logic [3:0] op);
    return (op >= 4'(OP_SB)) && (op <= 4'(OP_SW));
  endfunction

  // Bit offset of channel 'ch' in a bus packed with 'width' bits per channel.
  function automatic int cdb_lsb(input int ch, input int width);
    return ch * width;
  endfunction

endpackage

// File: rtl/lsq_multi_cdb_cdb_match.sv
// lsq_cdb_match: combinational match of one operand tag against all
// broadcast channels.
// Ports:
//   tag        operand producer tag (tag 0 never matches)
//   cdb_valid  per-channel valid
//   cdb_tag    packed channel tags, channel 0 in the LSBs
//   cdb_data   packed channel results, channel 0 in the LSBs
//   hit        some valid channel carries this tag
//   data       result of the lowest-index matching channel
module lsq_cdb_match
  import lsq_multi_cdb_pkg::*;
#(
  parameter int TAG_W = 4,
  parameter int CDB_N = 2
) (
  input  logic [TAG_W-1:0]       tag,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*32-1:0]    cdb_data,
  output logic                   hit,
  output logic [31:0]            data
);

  // Scan from the highest channel down so the lowest matching index is the
  // last to write and therefore wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int i = CDB_N - 1; i >= 0; i--) begin
      if ((tag != TAG_W'(TAG_NONE)) && cdb_valid[i] &&
          (cdb_tag[cdb_lsb(i, TAG_W) +: TAG_W] == tag)) begin
        hit  = 1'b1;
        data = cdb_data[cdb_lsb(i, 32) +: 32];
      end
    end
  end

endmodule

// File: rtl/lsq_multi_cdb.sv
// lsq_multi_cdb: circular load/store queue between dispatcher, ROB and LSU.
// Entries wake their operands from CDB_N broadcast channels, loads issue once
// resolved (MMIO loads only at ROB head), stores issue only after commit.
// One LSU request is outstanding at a time; load data returns with its tag.
// Optional feature macro: LSQ_LOAD_BYPASS_EN lets a ready non-IO load issue
// past older, address-resolved, non-conflicting stores when the head stalls.
// Ports:
//   clk_in, rst_in (sync, active high), rdy_in (global stall when low)
//   disp_*         insert request from the dispatcher; full = back-pressure
//   cdb_*          packed broadcast channels
//   commit_*       ROB commit pulse; io_head_rob/io_rob for MMIO ordering
//   rollback       flush all but committed stores
//   lsu_*          single-request LSU handshake
//   res_*          load result pulse
module lsq_multi_cdb
  import lsq_multi_cdb_pkg::*;
#(
  parameter int          DEPTH        = 16,
  parameter int          TAG_W        = 4,
  parameter int          CDB_N        = 2,
  parameter int          FULL_RESERVE = 2,
  parameter logic [31:0] IO_ADDR      = IO_ADDR_DEFAULT
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   disp_valid,
  input  logic [3:0]             disp_op,
  input  logic [31:0]            disp_v1,
  input  logic [31:0]            disp_v2,
  input  logic [31:0]            disp_imm,
  input  logic [TAG_W-1:0]       disp_q1,
  input  logic [TAG_W-1:0]       disp_q2,
  input  logic [TAG_W-1:0]       disp_rob,
  output logic                   full,
  input  logic [CDB_N-1:0]       cdb_valid,
  input  logic [CDB_N*TAG_W-1:0] cdb_tag,
  input  logic [CDB_N*32-1:0]    cdb_data,
  input  logic                   commit_valid,
  input  logic [TAG_W-1:0]       commit_rob,
  input  logic [TAG_W-1:0]       io_head_rob,
  output logic [TAG_W-1:0]       io_rob,
  input  logic                   rollback,
  input  logic                   lsu_busy,
  input  logic                   lsu_done,
  input  logic [31:0]            lsu_rdata,
  output logic                   lsu_req,
  output logic                   lsu_we,
  output logic [3:0]             lsu_op,
  output logic [31:0]            lsu_addr,
  output logic [31:0]            lsu_wdata,
  output logic                   res_valid,
  output logic [TAG_W-1:0]       res_tag,
  output logic [31:0]            res_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [DEPTH-1:0] valid_q, valid_d, committed_q, committed_d;
  logic [3:0]       op_q  [DEPTH];
  logic [3:0]       op_d  [DEPTH];
  logic [31:0]      v1_q  [DEPTH];
  logic [31:0]      v1_d  [DEPTH];
  logic [31:0]      v2_q  [DEPTH];
  logic [31:0]      v2_d  [DEPTH];
  logic [31:0]      imm_q [DEPTH];
  logic [31:0]      imm_d [DEPTH];
  logic [TAG_W-1:0] q1_q  [DEPTH];
  logic [TAG_W-1:0] q1_d  [DEPTH];
  logic [TAG_W-1:0] q2_q  [DEPTH];
  logic [TAG_W-1:0] q2_d  [DEPTH];
  logic [TAG_W-1:0] rob_q [DEPTH];
  logic [TAG_W-1:0] rob_d [DEPTH];

  ptr_t       head_q, head_d, tail_q, tail_d, cstore_tail_q, cstore_tail_d;
  cnt_t       count_q, count_d;
  logic       cstore_any_q, cstore_any_d;
  lsq_state_e state_q, state_d;
  logic       pend_load_q, pend_load_d;
  logic [TAG_W-1:0] pend_tag_q, pend_tag_d;

  logic             lsu_req_q, lsu_req_d, lsu_we_q, lsu_we_d;
  logic [3:0]       lsu_op_q, lsu_op_d;
  logic [31:0]      lsu_addr_q, lsu_addr_d, lsu_wdata_q, lsu_wdata_d;

  logic [DEPTH-1:0] q1_hit, q2_hit, ready;
  logic [31:0]      q1_data [DEPTH];
  logic [31:0]      q2_data [DEPTH];
  logic [31:0]      addr    [DEPTH];
  logic             ins_q1_hit, ins_q2_hit;
  logic [31:0]      ins_q1_data, ins_q2_data;

  logic head_ok, byp_ok, issue_go, inc, dec;
  ptr_t byp_idx, issue_idx, rb_diff;

  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    lsq_cdb_match #(.TAG_W(TAG_W), .CDB_N(CDB_N)) u_m1 (
      .tag(q1_q[g]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .hit(q1_hit[g]), .data(q1_data[g]));
    lsq_cdb_match #(.TAG_W(TAG_W), .CDB_N(CDB_N)) u_m2 (
      .tag(q2_q[g]), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
      .cdb_data(cdb_data), .hit(q2_hit[g]), .data(q2_data[g]));
  end

  lsq_cdb_match #(.TAG_W(TAG_W), .CDB_N(CDB_N)) u_ins1 (
    .tag(disp_q1), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .hit(ins_q1_hit), .data(ins_q1_data));
  lsq_cdb_match #(.TAG_W(TAG_W), .CDB_N(CDB_N)) u_ins2 (
    .tag(disp_q2), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .hit(ins_q2_hit), .data(ins_q2_data));

  // An entry is ready when both operands are resolved and either it is a
  // committed store or a load that is not held back by MMIO ordering.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      addr[i]  = v1_q[i] + imm_q[i];
      ready[i] = valid_q[i] && (q1_q[i] == '0) && (q2_q[i] == '0) &&
                 (is_store_op(op_q[i]) ? committed_q[i]
                                       : ((addr[i] != IO_ADDR) || (io_head_rob == rob_q[i])));
    end
  end

`ifdef LSQ_LOAD_BYPASS_EN
  ptr_t byp_scan;
  logic byp_found, byp_older_ok;
  cnt_t byp_load_k;

  // The only bypass candidate is the oldest load; it qualifies only if every
  // older live entry is a store whose address is already known and none of
  // those stores touches the same word.
  always_comb begin
    byp_ok       = 1'b0;
    byp_idx      = head_q;
    byp_found    = 1'b0;
    byp_older_ok = 1'b1;
    byp_load_k   = '0;
    byp_scan     = head_q;
    for (int k = 0; k < DEPTH; k++) begin
      byp_scan = head_q + ptr_t'(k);
      if ((cnt_t'(k) < count_q) && valid_q[byp_scan] && !byp_found) begin
        if (is_store_op(op_q[byp_scan])) begin
          if (q1_q[byp_scan] != '0) byp_older_ok = 1'b0;
        end else begin
          byp_found  = 1'b1;
          byp_idx    = byp_scan;
          byp_load_k = cnt_t'(k);
          byp_ok     = (k != 0) && byp_older_ok && (q1_q[byp_scan] == '0) &&
                       (q2_q[byp_scan] == '0) && (addr[byp_scan] != IO_ADDR);
        end
      end
    end
    for (int k = 0; k < DEPTH; k++) begin
      byp_scan = head_q + ptr_t'(k);
      if ((cnt_t'(k) < byp_load_k) && valid_q[byp_scan] && is_store_op(op_q[byp_scan]) &&
          (addr[byp_scan][31:2] == addr[byp_idx][31:2])) begin
        byp_ok = 1'b0;
      end
    end
  end
`else
  assign byp_ok  = 1'b0;
  assign byp_idx = head_q;
`endif

  assign head_ok   = ready[head_q];
  assign issue_go  = (state_q == ST_IDLE) && !lsu_busy && (head_ok || byp_ok);
  assign issue_idx = head_ok ? head_q : byp_idx;

  // Next-state logic: rollback overrides everything; otherwise wakeup,
  // commit, issue/FSM, head skip and insert are applied in that order.
  always_comb begin
    valid_d       = valid_q;
    committed_d   = committed_q;
    op_d          = op_q;
    v1_d          = v1_q;
    v2_d          = v2_q;
    imm_d         = imm_q;
    q1_d          = q1_q;
    q2_d          = q2_q;
    rob_d         = rob_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    cstore_tail_d = cstore_tail_q;
    cstore_any_d  = cstore_any_q;
    state_d       = state_q;
    pend_load_d   = pend_load_q;
    pend_tag_d    = pend_tag_q;
    lsu_req_d     = 1'b0;
    lsu_we_d      = lsu_we_q;
    lsu_op_d      = lsu_op_q;
    lsu_addr_d    = lsu_addr_q;
    lsu_wdata_d   = lsu_wdata_q;
    inc           = 1'b0;
    dec           = 1'b0;
    rb_diff       = '0;

    if (rollback) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (!(valid_q[i] && committed_q[i] && is_store_op(op_q[i]))) begin
          valid_d[i]     = 1'b0;
          committed_d[i] = 1'b0;
        end
      end
      // Surviving committed stores are contiguous from head; a zero
      // distance with a surviving store means the queue is full.
      tail_d  = cstore_any_q ? (cstore_tail_q + ptr_t'(1)) : head_q;
      rb_diff = tail_d - head_q;
      if (cstore_any_q && (rb_diff == '0)) count_d = cnt_t'(DEPTH);
      else                                 count_d = cnt_t'(rb_diff);
      // The in-flight request completes but its load result is dropped.
      pend_load_d = 1'b0;
      if ((state_q == ST_WAIT) && lsu_done) state_d = ST_IDLE;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (q1_hit[i]) begin
          v1_d[i] = q1_data[i];
          q1_d[i] = '0;
        end
        if (q2_hit[i]) begin
          v2_d[i] = q2_data[i];
          q2_d[i] = '0;
        end
        if (commit_valid && valid_q[i] && (rob_q[i] == commit_rob)) committed_d[i] = 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (issue_go) begin
            lsu_req_d              = 1'b1;
            lsu_we_d               = is_store_op(op_q[issue_idx]);
            lsu_op_d               = op_q[issue_idx];
            lsu_addr_d             = addr[issue_idx];
            lsu_wdata_d            = v2_q[issue_idx];
            pend_load_d            = !is_store_op(op_q[issue_idx]);
            pend_tag_d             = rob_q[issue_idx];
            valid_d[issue_idx]     = 1'b0;
            committed_d[issue_idx] = 1'b0;
            state_d                = ST_WAIT;
            if (cstore_any_q && (cstore_tail_q == issue_idx)) cstore_any_d = 1'b0;
            if (head_ok) begin
              head_d = head_q + ptr_t'(1);
              dec    = 1'b1;
            end
          end
        end
        ST_WAIT: begin
          if (lsu_done) begin
            state_d     = ST_IDLE;
            pend_load_d = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      // Holes left by rollback or in-place bypass are retired one per cycle.
      if (!valid_q[head_q] && (count_q != '0)) begin
        head_d = head_q + ptr_t'(1);
        dec    = 1'b1;
      end

      // A commit in the same cycle as an older store issuing must still win.
      for (int i = 0; i < DEPTH; i++) begin
        if (commit_valid && valid_q[i] && (rob_q[i] == commit_rob) && is_store_op(op_q[i])) begin
          cstore_tail_d = ptr_t'(i);
          cstore_any_d  = 1'b1;
        end
      end

      if (disp_valid) begin
        valid_d[tail_q]     = 1'b1;
        committed_d[tail_q] = 1'b0;
        op_d[tail_q]        = disp_op;
        imm_d[tail_q]       = disp_imm;
        rob_d[tail_q]       = disp_rob;
        v1_d[tail_q]        = ins_q1_hit ? ins_q1_data : disp_v1;
        q1_d[tail_q]        = ins_q1_hit ? '0 : disp_q1;
        v2_d[tail_q]        = ins_q2_hit ? ins_q2_data : disp_v2;
        q2_d[tail_q]        = ins_q2_hit ? '0 : disp_q2;
        tail_d              = tail_q + ptr_t'(1);
        inc                 = 1'b1;
      end

      count_d = count_q + cnt_t'(inc) - cnt_t'(dec);
    end
  end

  // State register; a low rdy_in freezes everything except the request
  // pulse, which must not repeat.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        op_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        imm_q[i] <= '0;
        q1_q[i]  <= '0;
        q2_q[i]  <= '0;
        rob_q[i] <= '0;
      end
      valid_q       <= '0;
      committed_q   <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      cstore_tail_q <= '0;
      cstore_any_q  <= 1'b0;
      state_q       <= ST_IDLE;
      pend_load_q   <= 1'b0;
      pend_tag_q    <= '0;
      lsu_req_q     <= 1'b0;
      lsu_we_q      <= 1'b0;
      lsu_op_q      <= '0;
      lsu_addr_q    <= '0;
      lsu_wdata_q   <= '0;
    end else if (rdy_in) begin
      op_q          <= op_d;
      v1_q          <= v1_d;
      v2_q          <= v2_d;
      imm_q         <= imm_d;
      q1_q          <= q1_d;
      q2_q          <= q2_d;
      rob_q         <= rob_d;
      valid_q       <= valid_d;
      committed_q   <= committed_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      cstore_tail_q <= cstore_tail_d;
      cstore_any_q  <= cstore_any_d;
      state_q       <= state_d;
      pend_load_q   <= pend_load_d;
      pend_tag_q    <= pend_tag_d;
      lsu_req_q     <= lsu_req_d;
      lsu_we_q      <= lsu_we_d;
      lsu_op_q      <= lsu_op_d;
      lsu_addr_q    <= lsu_addr_d;
      lsu_wdata_q   <= lsu_wdata_d;
    end else begin
      lsu_req_q <= 1'b0;
    end
  end

  assign full      = count_q >= cnt_t'(DEPTH - FULL_RESERVE);
  assign io_rob    = (valid_q[head_q] && (addr[head_q] == IO_ADDR)) ? rob_q[head_q] : '0;
  assign lsu_req   = lsu_req_q;
  assign lsu_we    = lsu_we_q;
  assign lsu_op    = lsu_op_q;
  assign lsu_addr  = lsu_addr_q;
  assign lsu_wdata = lsu_wdata_q;
  assign res_valid = rdy_in && (state_q == ST_WAIT) && lsu_done && pend_load_q && !rollback;
  assign res_tag   = res_valid ? pend_tag_q : '0;
  assign res_data  = res_valid ? lsu_rdata : '0;

endmodule

// File: tb/tb_lsq_multi_cdb.sv
// Directed testbench for lsq_multi_cdb with default parameters
// (DEPTH 16, TAG_W 4, CDB_N 2, FULL_RESERVE 2). Inputs change 1 ns after
// the rising edge, outputs are checked at that point as well.
module tb_lsq_multi_cdb;
  import lsq_multi_cdb_pkg::*;

  logic        clk_in, rst_in, rdy_in;
  logic        disp_valid;
  logic [3:0]  disp_op;
  logic [31:0] disp_v1, disp_v2, disp_imm;
  logic [3:0]  disp_q1, disp_q2, disp_rob;
  logic        full;
  logic [1:0]  cdb_valid;
  logic [7:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        commit_valid;
  logic [3:0]  commit_rob, io_head_rob, io_rob;
  logic        rollback, lsu_busy, lsu_done;
  logic [31:0] lsu_rdata;
  logic        lsu_req, lsu_we;
  logic [3:0]  lsu_op;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        res_valid;
  logic [3:0]  res_tag;
  logic [31:0] res_data;

  int checks = 0;
  int errors = 0;

  lsq_multi_cdb dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1),
    .disp_v2(disp_v2), .disp_imm(disp_imm), .disp_q1(disp_q1),
    .disp_q2(disp_q2), .disp_rob(disp_rob), .full(full),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .commit_valid(commit_valid), .commit_rob(commit_rob),
    .io_head_rob(io_head_rob), .io_rob(io_rob), .rollback(rollback),
    .lsu_busy(lsu_busy), .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_op(lsu_op),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .res_valid(res_valid),
    .res_tag(res_tag), .res_data(res_data)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic apply_insert(input logic [3:0] op, input logic [31:0] v1, input logic [31:0] v2,
                              input logic [31:0] imm, input logic [3:0] q1, input logic [3:0] q2,
                              input logic [3:0] rob);
    disp_op = op; disp_v1 = v1; disp_v2 = v2; disp_imm = imm;
    disp_q1 = q1; disp_q2 = q2; disp_rob = rob; disp_valid = 1'b1;
    step();
    disp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; disp_valid = 1'b0; disp_op = '0;
    disp_v1 = '0; disp_v2 = '0; disp_imm = '0; disp_q1 = '0; disp_q2 = '0;
    disp_rob = '0; cdb_valid = '0; cdb_tag = '0; cdb_data = '0;
    commit_valid = 1'b0; commit_rob = '0; io_head_rob = '0; rollback = 1'b0;
    lsu_busy = 1'b0; lsu_done = 1'b0; lsu_rdata = '0;
    step(); step();
    rst_in = 1'b0;
    checks++; if (lsu_req !== 1'b0)  begin errors++; $display("[TB] FAIL reset_req got %b expected 0", lsu_req); end
    checks++; if (full !== 1'b0)     begin errors++; $display("[TB] FAIL reset_full got %b expected 0", full); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_res got %b expected 0", res_valid); end
    checks++; if (io_rob !== 4'd0)   begin errors++; $display("[TB] FAIL reset_io_rob got %h expected 0", io_rob); end
    checks++; if (lsu_addr !== 32'd0 || lsu_we !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_lsu got addr %h we %b expected 0/0", lsu_addr, lsu_we);
    end
  endtask

  task automatic test_load();
    apply_insert(4'(OP_LW), 32'h100, 32'h0, 32'h4, 4'd0, 4'd0, 4'd1);
    checks++; if (lsu_req !== 1'b0) begin errors++; $display("[TB] FAIL load_early got %b expected 0", lsu_req); end
    step();
    checks++; if (lsu_req !== 1'b1 || lsu_addr !== 32'h104 || lsu_we !== 1'b0 || lsu_op !== 4'd2) begin
      errors++; $display("[TB] FAIL load_req got req %b addr %h we %b op %h expected 1/104/0/2", lsu_req, lsu_addr, lsu_we, lsu_op);
    end
    step();
    checks++; if (lsu_req !== 1'b0) begin errors++; $display("[TB] FAIL load_pulse got %b expected 0", lsu_req); end
    lsu_done = 1'b1; lsu_rdata = 32'hDEADBEEF; #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'hDEADBEEF || res_tag !== 4'd1) begin
      errors++; $display("[TB] FAIL load_res got v %b d %h t %h expected 1/deadbeef/1", res_valid, res_data, res_tag);
    end
    step(); lsu_done = 1'b0; #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL load_res_pulse got %b expected 0", res_valid); end
  endtask

  task automatic test_store_commit();
    apply_insert(4'(OP_SW), 32'h40, 32'h0, 32'h0, 4'd0, 4'd3, 4'd2);
    cdb_valid = 2'b10; cdb_tag = {4'd3, 4'd0}; cdb_data = {32'h55, 32'h0};
    step();
    cdb_valid = 2'b00;
    step(); step(); step();
    checks++; if (lsu_req !== 1'b0) begin errors++; $display("[TB] FAIL store_precommit got %b expected 0", lsu_req); end
    commit_valid = 1'b1; commit_rob = 4'd2;
    step();
    commit_valid = 1'b0;
    step();
    checks++; if (lsu_req !== 1'b1 || lsu_we !== 1'b1 || lsu_wdata !== 32'h55 || lsu_addr !== 32'h40) begin
      errors++; $display("[TB] FAIL store_req got req %b we %b wd %h addr %h expected 1/1/55/40", lsu_req, lsu_we, lsu_wdata, lsu_addr);
    end
    lsu_done = 1'b1; #1;
    checks++; if (res_valid !== 1'b0) begin errors++; $display("[TB] FAIL store_nores got %b expected 0", res_valid); end
    step(); lsu_done = 1'b0;
  endtask

  task automatic test_insert_bypass();
    cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd5}; cdb_data = {32'h999, 32'h200};
    apply_insert(4'(OP_LW), 32'h0, 32'h0, 32'h8, 4'd5, 4'd0, 4'd3);
    cdb_valid = 2'b00;
    step();
    checks++; if (lsu_req !== 1'b1 || lsu_addr !== 32'h208) begin
      errors++; $display("[TB] FAIL bypass_req got req %b addr %h expected 1/208", lsu_req, lsu_addr);
    end
    lsu_done = 1'b1; lsu_rdata = 32'h12345678; #1;
    checks++; if (res_valid !== 1'b1 || res_tag !== 4'd3 || res_data !== 32'h12345678) begin
      errors++; $display("[TB] FAIL bypass_res got v %b t %h d %h expected 1/3/12345678", res_valid, res_tag, res_data);
    end
    step(); lsu_done = 1'b0;
  endtask

  task automatic test_full_wrap();
    lsu_busy = 1'b1;
    for (int k = 0; k < 14; k++) begin
      apply_insert(4'(OP_LW), 32'h1000, 32'h0, 32'(4 * k), 4'd0, 4'd0, 4'(k + 1));
      if (k == 12) begin
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL full_13 got %b expected 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL full_14 got %b expected 1", full); end
    lsu_busy = 1'b0;
    step();
    checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL full_release got %b expected 0", full); end
    for (int k = 0; k < 14; k++) begin
      int n = 0;
      while (lsu_req !== 1'b1 && n < 10) begin step(); n++; end
      checks++; if (lsu_req !== 1'b1 || lsu_addr !== 32'h1000 + 32'(4 * k)) begin
        errors++; $display("[TB] FAIL wrap_req k=%0d got req %b addr %h expected 1/%h", k, lsu_req, lsu_addr, 32'h1000 + 32'(4 * k));
      end
      lsu_done = 1'b1; lsu_rdata = 32'hA000_0000 + 32'(k); #1;
      checks++; if (res_valid !== 1'b1 || res_tag !== 4'(k + 1) || res_data !== 32'hA000_0000 + 32'(k)) begin
        errors++; $display("[TB] FAIL wrap_res k=%0d got v %b t %h d %h expected 1/%h", k, res_valid, res_tag, res_data, 4'(k + 1));
      end
      step(); lsu_done = 1'b0;
    end
  endtask

  task automatic test_rollback();
    lsu_busy = 1'b1;
    apply_insert(4'(OP_SW), 32'h80, 32'h11, 32'h0, 4'd0, 4'd0, 4'd4);
    apply_insert(4'(OP_LW), 32'h0, 32'h0, 32'h900, 4'd7, 4'd0, 4'd5);
    apply_insert(4'(OP_SB), 32'h84, 32'h22, 32'h0, 4'd0, 4'd0, 4'd6);
    commit_valid = 1'b1; commit_rob = 4'd4;
    step();
    commit_valid = 1'b0;
    rollback = 1'b1;
    step();
    rollback = 1'b0;
    cdb_valid = 2'b01; cdb_tag = {4'd0, 4'd7}; cdb_data = 64'h0;
    step();
    cdb_valid = 2'b00;
    for (int j = 0; j < 13; j++) begin
      apply_insert(4'(OP_LW), 32'h2000, 32'h0, 32'(4 * j), 4'd0, 4'd0, 4'(j + 1));
      if (j == 11) begin
        checks++; if (full !== 1'b0) begin errors++; $display("[TB] FAIL rb_count13 got %b expected 0", full); end
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("[TB] FAIL rb_count14 got %b expected 1", full); end
    lsu_busy = 1'b0;
    for (int k = 0; k < 14; k++) begin
      int n = 0;
      logic [31:0] exp_addr;
      exp_addr = (k == 0) ? 32'h80 : 32'h2000 + 32'(4 * (k - 1));
      while (lsu_req !== 1'b1 && n < 10) begin step(); n++; end
      checks++; if (lsu_req !== 1'b1 || lsu_addr !== exp_addr || lsu_we !== (k == 0)) begin
        errors++; $display("[TB] FAIL rb_order k=%0d got req %b addr %h we %b expected 1/%h", k, lsu_req, lsu_addr, lsu_we, exp_addr);
      end
      if (k == 0) begin
        checks++; if (lsu_wdata !== 32'h11) begin errors++; $display("[TB] FAIL rb_store_data got %h expected 11", lsu_wdata); end
      end
      lsu_done = 1'b1; lsu_rdata = 32'h0; #1;
      checks++; if (res_valid !== (k != 0)) begin
        errors++; $display("[TB] FAIL rb_res k=%0d got %b expected %b", k, res_valid, (k != 0));
      end
      step(); lsu_done = 1'b0;
    end
  endtask

  task automatic test_io();
    io_head_rob = 4'd2;
    apply_insert(4'(OP_LW), 32'h30000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd9);
    checks++; if (io_rob !== 4'd9) begin errors++; $display("[TB] FAIL io_rob got %h expected 9", io_rob); end
    step(); step(); step();
    checks++; if (lsu_req !== 1'b0) begin errors++; $display("[TB] FAIL io_hold got %b expected 0", lsu_req); end
    io_head_rob = 4'd9;
    step();
    checks++; if (lsu_req !== 1'b1 || lsu_addr !== 32'h30000) begin
      errors++; $display("[TB] FAIL io_req got req %b addr %h expected 1/30000", lsu_req, lsu_addr);
    end
    checks++; if (io_rob !== 4'd0) begin errors++; $display("[TB] FAIL io_rob_clear got %h expected 0", io_rob); end
    lsu_done = 1'b1; lsu_rdata = 32'hCAFE; #1;
    checks++; if (res_valid !== 1'b1 || res_tag !== 4'd9) begin
      errors++; $display("[TB] FAIL io_res got v %b t %h expected 1/9", res_valid, res_tag);
    end
    step(); lsu_done = 1'b0; io_head_rob = 4'd0;
  endtask

  task automatic test_stall();
    apply_insert(4'(OP_LW), 32'h500, 32'h0, 32'h10, 4'd0, 4'd0, 4'd10);
    rdy_in = 1'b0;
    step(); step(); step();
    checks++; if (lsu_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_hold got %b expected 0", lsu_req); end
    rdy_in = 1'b1;
    step();
    checks++; if (lsu_req !== 1'b1 || lsu_addr !== 32'h510) begin
      errors++; $display("[TB] FAIL stall_req got req %b addr %h expected 1/510", lsu_req, lsu_addr);
    end
    rdy_in = 1'b0;
    step();
    checks++; if (lsu_req !== 1'b0 || lsu_addr !== 32'h510) begin
      errors++; $display("[TB] FAIL stall_pulse got req %b addr %h expected 0/510", lsu_req, lsu_addr);
    end
    rdy_in = 1'b1; lsu_done = 1'b1; lsu_rdata = 32'h77; #1;
    checks++; if (res_valid !== 1'b1 || res_data !== 32'h77 || res_tag !== 4'd10) begin
      errors++; $display("[TB] FAIL stall_res got v %b d %h t %h expected 1/77/a", res_valid, res_data, res_tag);
    end
    step(); lsu_done = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load();
    test_store_commit();
    test_insert_bypass();
    test_full_wrap();
    test_rollback();
    test_io();
    test_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsq_multi_cdb.md
Name: lsq_multi_cdb

Overview:
- Parametrised successor of the in-order load/store buffer.
- Accepts memory ops from the dispatcher and snoops N result-broadcast channels (ALU, LSU, …) to wake operands. Loads issue only when their operands are resolved; stores issue only after ROB commit.
- Keeps at most one request outstanding to the LSU and returns loaded data with its ROB tag.
- Sits between dispatcher, ROB and LSU. Rollback keeps committed stores and discards everything else.

Parameters:
- DEPTH, 16: queue entries; power of two, at least 4.
- TAG_W, 4: ROB id width. Tag 0 means "no dependency"; real ROB ids are 1..2^TAG_W-1.
- CDB_N, 2: number of broadcast channels snooped.
- FULL_RESERVE, 2: full asserts when count ≥ DEPTH-FULL_RESERVE.
- IO_ADDR, 32'h30000: MMIO address. A load to it issues only when the ROB says it is the head.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset
- rdy_in  in  1  global stall when low
- disp_valid  in  1  insert request
- disp_op  in  4  0-4 = LB,LH,LW,LBU,LHU; 5-7 = SB,SH,SW
- disp_v1, disp_v2, disp_imm  in  32 each  base, store data, offset
- disp_q1, disp_q2  in  TAG_W each  producer tags
- disp_rob  in  TAG_W  own ROB id
- full  out  1  back-pressure to dispatcher
- cdb_valid  in  CDB_N  per-channel valid
- cdb_tag  in  CDB_N*TAG_W  packed tags, channel 0 in the LSBs
- cdb_data  in  CDB_N*32  packed results
- commit_valid  in  1  ROB commit pulse
- commit_rob  in  TAG_W  committed ROB id
- io_head_rob  in  TAG_W  ROB head id used for MMIO ordering
- io_rob  out  TAG_W  head entry rob id if its address is IO_ADDR, else 0
- rollback  in  1  flush
- lsu_busy  in  1  LSU cannot accept
- lsu_done  in  1  request finished
- lsu_rdata  in  32  load data
- lsu_req  out  1  one-cycle request
- lsu_we  out  1  1 = store
- lsu_op  out  4  op
- lsu_addr  out  32  v1+imm, modulo 2^32
- lsu_wdata  out  32  store data
- res_valid  out  1  load result valid, one cycle
- res_tag  out  TAG_W  load ROB id
- res_data  out  32  load data

Behaviour:
- Reset is synchronous and active-high (rst_in).
  - All outputs go to 0; head, tail and count go to 0; all valid/committed bits clear.
  - The FSM goes to IDLE.
- rdy_in=0: no state changes, outputs hold their values (lsu_req and res_valid still pulse only once).
- Insert on disp_valid at tail; tail wraps at DEPTH.
  - Same-cycle CDB bypass: if disp_q1/q2 matches a valid channel, store that data and tag 0.
  - The lowest-index matching channel wins.
  - The dispatcher never asserts disp_valid while full; if it does, the result is undefined.
- Wakeup: every entry compares q1/q2 against all CDB_N channels each cycle.
- Commit: the entry with matching rob id and valid sets committed.
  - For a store, cstore_tail is set to that index and cstore_any to 1.
- FSM has two states, IDLE and WAIT.
  - IDLE: issue when the head entry is valid, q1=q2=0 and lsu_busy=0, and one of:
    - a load whose address ≠ IO_ADDR;
    - a load whose address = IO_ADDR and io_head_rob equals its rob id;
    - a committed store.
  - On issue: assert lsu_req for 1 cycle, free the head, advance head, go to WAIT.
  - WAIT: on lsu_done go to IDLE. For a load, res_valid/res_tag/res_data pulse in the same cycle as lsu_done.
  - Issue-to-next-issue latency is at least 2 cycles.
- Count: +1 on insert, -1 on issue; simultaneous insert and issue leaves it unchanged.
  - Count reaches DEPTH exactly when head==tail and the entry at head is valid.
- Rollback has priority over insert, issue, commit and wakeup.
  - Clear every entry that is uncommitted, plus every load (committed or not).
  - tail becomes cstore_tail+1, or head if cstore_any=0. count is recomputed with wrap.
  - An in-flight request is not cancelled. A pending load completion in WAIT still returns to IDLE, but res_valid is suppressed.
- When the store at cstore_tail issues, cstore_any clears.

Optional Feature:
- Macro: LSQ_LOAD_BYPASS_EN.
- Defined: in IDLE, when the head is not issuable, the oldest ready non-IO load may issue if:
  - every older entry is a store with q1=0;
  - no older store's word address (addr[31:2]) equals the load's word address.
- The bypassing entry is cleared in place. Head skips invalid entries, one per cycle.
- Undefined: strict in-order issue from head only.

Decomposition:
- Shared package holds: op encodings; tag-0 constant; IO_ADDR default; a packed-CDB slice helper.
- One sub-module, lsq_cdb_match: combinational per-operand match across CDB_N channels, giving hit and data. It is instantiated per entry operand and at the insert port.

Test Plan:
1. Reset, then insert LW q1=0, v1=0x100, imm=4 → lsu_req with addr 0x104, we=0; lsu_done with rdata 0xDEADBEEF → res_valid, res_data=0xDEADBEEF.
2. Insert SW q2=3; CDB channel 1 broadcasts tag 3, data 0x55 → no issue before commit. After commit_rob matches → lsu_req with we=1, wdata=0x55.
3. Insert with disp_q1=5 in the same cycle that channel 0 broadcasts tag 5, data 0x200 → entry stored with v1=0x200, q1=0; issues the next cycle.
4. Fill until count=DEPTH-FULL_RESERVE → full=1. One issue with no insert → full=0. Tail wraps from DEPTH-1 to 0.
5. Entries in order: committed SW, uncommitted LW, uncommitted SB; rollback → only the SW remains, tail = its index+1, count=1.
6. Load to 0x30000 with io_head_rob≠its rob id → io_rob=rob id, no request. Set io_head_rob equal → lsu_req.
